spm_cfg_sequencer: RTL and testbench
====================================

Name: spm_cfg_sequencer

Overview:
Parametrised successor to the scratchpad control path. It holds a DEPTH-entry configuration buffer loaded through a valid/ready port, and a run sequencer that supports per-entry hold counts, whole-program looping, stall/pause and a done pulse. Per cycle it routes either the external port or the per-group switch port to each of NUM_BG bank-group control interfaces. Bank-group instances stay outside this block and connect to its bg_* outputs.

Parameters:
NUM_BG, 4, number of bank groups / switch ports
D_W, 32, data width
A_W, 8, address width
DEPTH, 16, configuration buffer entries (power of 2, >=2)
FSEL_W, 2, fifo_sel width per bank group
HOLD_W, 8, per-entry hold-count width
LOOP_W, 16, loop-count width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
cfg_valid  in  1  config entry offered
cfg_ready  out  1  buffer can accept an entry
cfg_entry  in  ENT_W  {hold[HOLD_W], per-BG fields BG(N-1)..BG0}; each BG field = {flush, fifo_sel[FSEL_W], en, sel, mode}
cfg_clear  in  1  empties the buffer (count := 0)
start  in  1  begin program
loop_cnt  in  LOOP_W  extra passes after the first, sampled at start
stall  in  1  pause sequencing
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at program end
ex_wen, ex_ren  in  1 each  external port strobes
ex_addr  in  A_W  external address
ex_data  in  D_W  external write data
sw_wen, sw_ren  in  NUM_BG each  switch-port strobes
sw_addr  in  NUM_BG*A_W  switch-port addresses
sw_data  in  NUM_BG*D_W  switch-port data
bg_en, bg_mode, bg_we, bg_re, bg_flush  out  NUM_BG each  bank-group controls
bg_fifo_sel  out  NUM_BG*FSEL_W  bank-group fifo selects
bg_addr  out  NUM_BG*A_W  bank-group addresses
bg_din  out  NUM_BG*D_W  bank-group write data

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; count=0; rd_ptr=0; hold_ctr=0; loop_ctr=0.
  - cur_entry=0, so all bg_* outputs are 0.
  - done=0, busy=0.
  - Buffer RAM contents are not cleared.
- Reset mid-run aborts immediately with no done pulse.
- States:
  - IDLE -> RUN on start when count>0. start with count==0 is ignored.
  - RUN -> PAUSE on stall.
  - PAUSE -> RUN when stall==0.
  - RUN -> DONE when the last pass finishes.
  - DONE -> IDLE after 1 cycle; done=1 only in DONE.
- Loading:
  - cfg_ready = (state==IDLE) && (count<DEPTH).
  - A handshake writes buf[count] and increments count.
  - cfg_clear in IDLE sets count=0 and has priority over a same-cycle handshake. cfg_clear outside IDLE is ignored.
  - cfg_valid while full is dropped and count is unchanged.
- Run:
  - On the start edge: cur_entry<=buf[0], hold_ctr<=buf[0].hold, loop_ctr<=loop_cnt, rd_ptr<=1 mod count.
  - Entry k is therefore visible on bg_* one cycle after start.
  - Each RUN cycle with hold_ctr>0 decrements hold_ctr; an entry stays active for hold+1 RUN cycles.
  - When hold_ctr==0, the next entry is loaded. After entry count-1:
    - if loop_ctr>0: wrap to entry 0 and decrement loop_ctr;
    - else: go to DONE and zero cur_entry.
  - If start and stall are asserted together in IDLE, start wins; stall takes effect the following cycle.
- PAUSE:
  - cur_entry, hold_ctr, rd_ptr and loop_ctr are frozen.
  - bg_we, bg_re and bg_flush are forced to 0; bg_en, bg_mode and bg_fifo_sel hold their values.
  - Stall asserted in the same cycle as an entry advance: the advance completes first, then the sequencer pauses.
- Routing (combinational from cur_entry):
  - Per group i: sel_i=1 chooses sw_*[i]; sel_i=0 chooses the ex_* port, broadcast to every group with sel=0.
  - Outside RUN, bg_we, bg_re and bg_flush are forced to 0.
  - bg_flush is asserted only in the first cycle of an entry, not repeated during its hold cycles.

Optional Feature:
SPM_PERF_CNT_EN
- With the macro defined, add two outputs:
  - perf_run_cyc[31:0] counts RUN cycles;
  - perf_stall_cyc[31:0] counts PAUSE cycles.
  - Both clear on reset and on start, and saturate at all-ones.
- Without the macro: no ports and no logic.

Decomposition:
- Package spm_cfg_pkg holds:
  - BG field layout offsets and BGF_W = 4+FSEL_W;
  - ENT_W = HOLD_W + NUM_BG*BGF_W;
  - state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3).
- Sub-module spm_bg_route: per-group mux plus gating, instantiated NUM_BG times in a generate loop.
- The sequencer FSM and the buffer live in the top module.

Test Plan:
1. Load 3 entries with hold {0,2,1}, loop_cnt=0, pulse start.
   -> bg outputs show E0 for 1 cycle, E1 for 3, E2 for 2; done pulses at cycle 7 after start; busy low at cycle 8.
2. Same program with loop_cnt=2.
   -> sequence E0,E1,E1,E1,E2,E2 repeats 3 times; exactly one done pulse.
3. Load 16 entries, offer a 17th.
   -> cfg_ready=0 and count stays 16. Then cfg_clear with cfg_valid together -> count=0.
4. Stall held 4 cycles during E1 of test 1.
   -> bg_we and bg_re are 0 and bg_en is held for those cycles; the E1 total active cycles are still 3; done is delayed by 4.
5. BG0 sel=1, BG1/BG2 sel=0, ex_addr=0x5A, sw_addr[0]=0x11.
   -> bg_addr0=0x11, bg_addr1=bg_addr2=0x5A. A start with count==0 is ignored (busy stays 0).
6. Drive rst=0 for one cycle mid-run.
   -> next cycle all bg_* are 0, state is IDLE, no done pulse, count=0.

Source files
------------

// File: rtl/spm_cfg_pkg.sv
// spm_cfg_pkg: shared definitions for the scratchpad configuration sequencer.
//   - Bank-group field layout inside a configuration entry. Each field is
//     {flush, fifo_sel[FSEL_W], en, sel, mode}, LSB first: mode, sel, en,
//     fifo_sel, flush.
//   - Width helpers, because FSEL_W/HOLD_W/NUM_BG are parameters of the
//     modules that use them. BGF_W and ENT_W are the widths for the default
//     parameter set.
//   - Sequencer state encoding.
package spm_cfg_pkg;

  localparam int BGF_MODE = 0;
  localparam int BGF_SEL  = 1;
  localparam int BGF_EN   = 2;
  localparam int BGF_FSEL = 3;

  // Width of one bank-group field.
  function automatic int bgf_w(input int fsel_w);
    return 4 + fsel_w;
  endfunction

  // Position of the flush bit, which sits directly above fifo_sel.
  function automatic int bgf_flush(input int fsel_w);
    return 3 + fsel_w;
  endfunction

  // Width of a whole entry: the hold count on top of NUM_BG fields.
  function automatic int ent_w(input int hold_w, input int num_bg, input int fsel_w);
    return hold_w + num_bg * bgf_w(fsel_w);
  endfunction

  localparam int NUM_BG_DEF = 4;
  localparam int FSEL_W_DEF = 2;
  localparam int HOLD_W_DEF = 8;
  localparam int BGF_W      = 4 + FSEL_W_DEF;
  localparam int ENT_W      = HOLD_W_DEF + NUM_BG_DEF * BGF_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/spm_bg_route.sv
// spm_bg_route: control routing for one bank group.
//   Selects either the shared external port (sel=0) or this group's switch
//   port (sel=1), and gates the strobes so they only reach the bank group
//   while the sequencer is actively running.
// Ports:
//   fld                        bank-group field of the current entry
//   run                        sequencer is in RUN
//   first                      first RUN cycle of the current entry
//   ex_wen/ex_ren/ex_addr/ex_data   external port (shared by all groups)
//   sw_wen/sw_ren/sw_addr/sw_data   this group's switch port
//   en/mode/fifo_sel           static controls, taken straight from fld
//   we/re/flush                gated strobes
//   addr/din                   routed address / write data
module spm_bg_route
  import spm_cfg_pkg::*;
#(
  parameter int D_W    = 32,
  parameter int A_W    = 8,
  parameter int FSEL_W = 2
) (
  input  logic [FSEL_W+3:0] fld,
  input  logic              run,
  input  logic              first,
  input  logic              ex_wen,
  input  logic              ex_ren,
  input  logic [A_W-1:0]    ex_addr,
  input  logic [D_W-1:0]    ex_data,
  input  logic              sw_wen,
  input  logic              sw_ren,
  input  logic [A_W-1:0]    sw_addr,
  input  logic [D_W-1:0]    sw_data,
  output logic              en,
  output logic              mode,
  output logic [FSEL_W-1:0] fifo_sel,
  output logic              we,
  output logic              re,
  output logic              flush,
  output logic [A_W-1:0]    addr,
  output logic [D_W-1:0]    din
);

  localparam int FLUSH_B = bgf_flush(FSEL_W);

  logic sel;

  always_comb begin
    sel      = fld[BGF_SEL];
    en       = fld[BGF_EN];
    mode     = fld[BGF_MODE];
    fifo_sel = fld[BGF_FSEL +: FSEL_W];
    we       = run & (sel ? sw_wen : ex_wen);
    re       = run & (sel ? sw_ren : ex_ren);
    // Flush is a one-shot per entry; hold cycles must not re-flush.
    flush    = run & first & fld[FLUSH_B];
    // Disabled groups see quiet address/data buses, so an idle or reset
    // sequencer (all fields zero) drives nothing at all.
    addr     = en ? (sel ? sw_addr : ex_addr) : '0;
    din      = en ? (sel ? sw_data : ex_data) : '0;
  end

endmodule

// File: rtl/spm_cfg_sequencer.sv
// spm_cfg_sequencer: configuration buffer plus run sequencer that drives
// NUM_BG bank-group control interfaces.
//   Entries are loaded through cfg_valid/cfg_ready while IDLE. start replays
//   entries 0..count-1, each for hold+1 RUN cycles, for loop_cnt+1 passes,
//   then pulses done for one cycle. stall pauses sequencing (strobes forced
//   low, static controls held).
// Optional build macro: SPM_PERF_CNT_EN adds perf_run_cyc / perf_stall_cyc
//   (RUN and PAUSE cycle counters, cleared on reset and start, saturating).
// Ports:
//   clk, rst (synchronous, active-low)
//   cfg_valid, cfg_ready, cfg_entry, cfg_clear     buffer load port
//   start, loop_cnt, stall, busy, done              run control / status
//   ex_*                                            external port
//   sw_*                                            per-group switch ports
//   bg_*                                            bank-group controls
module spm_cfg_sequencer
  import spm_cfg_pkg::*;
#(
  parameter int NUM_BG = 4,
  parameter int D_W    = 32,
  parameter int A_W    = 8,
  parameter int DEPTH  = 16,
  parameter int FSEL_W = 2,
  parameter int HOLD_W = 8,
  parameter int LOOP_W = 16,
  localparam int BGF_B = bgf_w(FSEL_W),
  localparam int ENT_B = ent_w(HOLD_W, NUM_BG, FSEL_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ENT_B-1:0]         cfg_entry,
  input  logic                     cfg_clear,
  input  logic                     start,
  input  logic [LOOP_W-1:0]        loop_cnt,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
`ifdef SPM_PERF_CNT_EN
  output logic [31:0]              perf_run_cyc,
  output logic [31:0]              perf_stall_cyc,
`endif
  input  logic                     ex_wen,
  input  logic                     ex_ren,
  input  logic [A_W-1:0]           ex_addr,
  input  logic [D_W-1:0]           ex_data,
  input  logic [NUM_BG-1:0]        sw_wen,
  input  logic [NUM_BG-1:0]        sw_ren,
  input  logic [NUM_BG*A_W-1:0]    sw_addr,
  input  logic [NUM_BG*D_W-1:0]    sw_data,
  output logic [NUM_BG-1:0]        bg_en,
  output logic [NUM_BG-1:0]        bg_mode,
  output logic [NUM_BG-1:0]        bg_we,
  output logic [NUM_BG-1:0]        bg_re,
  output logic [NUM_BG-1:0]        bg_flush,
  output logic [NUM_BG*FSEL_W-1:0] bg_fifo_sel,
  output logic [NUM_BG*A_W-1:0]    bg_addr,
  output logic [NUM_BG*D_W-1:0]    bg_din
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int FLD_W    = NUM_BG * BGF_B;
  localparam int HOLD_LSB = FLD_W;

  seq_state_t state_reg, state_next;

  logic [ENT_B-1:0]  buf_mem [DEPTH];
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [HOLD_W-1:0] hold_ctr_reg;
  logic [LOOP_W-1:0] loop_ctr_reg;
  logic [FLD_W-1:0]  cur_bg_reg;
  logic              first_reg;

  logic              cfg_hs;
  logic              clear_now;
  logic              do_start;
  logic              advance;
  logic              wrap;
  logic              finish;
  logic [PTR_W-1:0]  rd_addr;
  logic [CNT_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  rd_ptr_next;

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign cfg_ready = (state_reg == ST_IDLE) && (count_reg < CNT_W'(DEPTH));
  assign clear_now = (state_reg == ST_IDLE) && cfg_clear;
  assign cfg_hs    = cfg_valid && cfg_ready;

  // Entry being fetched this cycle: entry 0 on start, otherwise rd_ptr.
  // rd_ptr already points back at 0 when the current entry is the last one,
  // so a loop wrap fetches entry 0 without a special case.
  assign rd_addr     = do_start ? '0 : rd_ptr_reg;
  assign ptr_inc     = {1'b0, rd_addr} + CNT_W'(1);
  assign rd_ptr_next = (ptr_inc == count_reg) ? '0 : ptr_inc[PTR_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next state and datapath controls.
  always_comb begin
    state_next = state_reg;
    do_start   = 1'b0;
    advance    = 1'b0;
    wrap       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && (count_reg != '0)) begin
          do_start   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A RUN cycle is always processed, even with stall high; the pause
        // begins on the following cycle.
        if ((hold_ctr_reg == '0) && (rd_ptr_reg == '0) && (loop_ctr_reg == '0)) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end else begin
          advance = (hold_ctr_reg == '0);
          wrap    = (hold_ctr_reg == '0) && (rd_ptr_reg == '0);
          if (stall) state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!stall) state_next = ST_RUN;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Buffer storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && cfg_hs && !clear_now) buf_mem[count_reg[PTR_W-1:0]] <= cfg_entry;
  end

  // Sequencer datapath. cur_bg_reg/hold_ctr_reg are the registered read
  // of the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      hold_ctr_reg <= '0;
      loop_ctr_reg <= '0;
      cur_bg_reg   <= '0;
      first_reg    <= 1'b0;
    end else begin
      if (clear_now)   count_reg <= '0;
      else if (cfg_hs) count_reg <= count_reg + CNT_W'(1);

      if (do_start || advance) begin
        cur_bg_reg   <= buf_mem[rd_addr][FLD_W-1:0];
        hold_ctr_reg <= buf_mem[rd_addr][HOLD_LSB +: HOLD_W];
        rd_ptr_reg   <= rd_ptr_next;
        first_reg    <= 1'b1;
      end else if (finish) begin
        cur_bg_reg <= '0;
        first_reg  <= 1'b0;
      end else if (state_reg == ST_RUN) begin
        hold_ctr_reg <= hold_ctr_reg - HOLD_W'(1);
        first_reg    <= 1'b0;
      end

      if (do_start)  loop_ctr_reg <= loop_cnt;
      else if (wrap) loop_ctr_reg <= loop_ctr_reg - LOOP_W'(1);
    end
  end

  logic run_now;
  assign run_now = (state_reg == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BG; gi++) begin : g_bg
      spm_bg_route #(
        .D_W    (D_W),
        .A_W    (A_W),
        .FSEL_W (FSEL_W)
      ) u_route (
        .fld      (cur_bg_reg[gi*BGF_B +: BGF_B]),
        .run      (run_now),
        .first    (first_reg),
        .ex_wen   (ex_wen),
        .ex_ren   (ex_ren),
        .ex_addr  (ex_addr),
        .ex_data  (ex_data),
        .sw_wen   (sw_wen[gi]),
        .sw_ren   (sw_ren[gi]),
        .sw_addr  (sw_addr[gi*A_W +: A_W]),
        .sw_data  (sw_data[gi*D_W +: D_W]),
        .en       (bg_en[gi]),
        .mode     (bg_mode[gi]),
        .fifo_sel (bg_fifo_sel[gi*FSEL_W +: FSEL_W]),
        .we       (bg_we[gi]),
        .re       (bg_re[gi]),
        .flush    (bg_flush[gi]),
        .addr     (bg_addr[gi*A_W +: A_W]),
        .din      (bg_din[gi*D_W +: D_W])
      );
    end
  endgenerate

`ifdef SPM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst || do_start) begin
      perf_run_cyc   <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if ((state_reg == ST_RUN) && (perf_run_cyc != '1))
        perf_run_cyc <= perf_run_cyc + 32'd1;
      if ((state_reg == ST_PAUSE) && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_spm_cfg_sequencer.sv
module tb_spm_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_entry;
  logic        cfg_clear;
  logic        start;
  logic [15:0] loop_cnt;
  logic        stall;
  logic        busy;
  logic        done;
  logic        ex_wen, ex_ren;
  logic [7:0]  ex_addr;
  logic [31:0] ex_data;
  logic [3:0]  sw_wen, sw_ren;
  logic [31:0] sw_addr;
  logic [127:0] sw_data;
  logic [3:0]  bg_en, bg_mode, bg_we, bg_re, bg_flush;
  logic [7:0]  bg_fifo_sel;
  logic [31:0] bg_addr;
  logic [127:0] bg_din;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spm_cfg_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_entry   (cfg_entry),
    .cfg_clear   (cfg_clear),
    .start       (start),
    .loop_cnt    (loop_cnt),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .ex_wen      (ex_wen),
    .ex_ren      (ex_ren),
    .ex_addr     (ex_addr),
    .ex_data     (ex_data),
    .sw_wen      (sw_wen),
    .sw_ren      (sw_ren),
    .sw_addr     (sw_addr),
    .sw_data     (sw_data),
    .bg_en       (bg_en),
    .bg_mode     (bg_mode),
    .bg_we       (bg_we),
    .bg_re       (bg_re),
    .bg_flush    (bg_flush),
    .bg_fifo_sel (bg_fifo_sel),
    .bg_addr     (bg_addr),
    .bg_din      (bg_din)
  );

  // {flush, fifo_sel[1:0], en, sel, mode}
  function automatic logic [5:0] mk_bg(input logic fl, input logic [1:0] fs,
                                       input logic en, input logic sl, input logic md);
    return {fl, fs, en, sl, md};
  endfunction

  function automatic logic [31:0] mk_ent(input logic [7:0] hold, input logic [5:0] b3,
                                         input logic [5:0] b2, input logic [5:0] b1,
                                         input logic [5:0] b0);
    return {hold, b3, b2, b1, b0};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic [31:0] ent);
    cfg_entry = ent;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic clear_buf();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  // E0: hold 0, BG0 en+flush fsel1. E1: hold 2, BG0 en, BG1 en+mode+flush fsel2.
  // E2: hold 1, BG2 en fsel3, BG3 en+mode.
  task automatic load_prog3();
    clear_buf();
    load_entry(mk_ent(8'd0, 6'd0, 6'd0, 6'd0, mk_bg(1'b1, 2'd1, 1'b1, 1'b0, 1'b0)));
    load_entry(mk_ent(8'd2, 6'd0, 6'd0, mk_bg(1'b1, 2'd2, 1'b1, 1'b0, 1'b1),
                      mk_bg(1'b0, 2'd0, 1'b1, 1'b0, 1'b0)));
    load_entry(mk_ent(8'd1, mk_bg(1'b0, 2'd0, 1'b1, 1'b0, 1'b1),
                      mk_bg(1'b0, 2'd3, 1'b1, 1'b0, 1'b0), 6'd0, 6'd0));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (bg_en !== 4'h0) begin bad++; $display("FAIL reset_bg_en: got %h want 0", bg_en); end
    total++; if (bg_we !== 4'h0) begin bad++; $display("FAIL reset_bg_we: got %h want 0", bg_we); end
    total++; if (bg_addr !== 32'h0) begin bad++; $display("FAIL reset_bg_addr: got %h want 0", bg_addr); end
    total++; if (bg_din !== 128'h0) begin bad++; $display("FAIL reset_bg_din: got %h want 0", bg_din); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    rst = 1'b1;
    tick();
    $display("reset: checked idle outputs");
  endtask

  task automatic test_single_pass();
    logic [3:0] e_en   [8] = '{4'h1, 4'h3, 4'h3, 4'h3, 4'hC, 4'hC, 4'h0, 4'h0};
    logic [3:0] e_fl   [8] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [7:0] e_fs   [8] = '{8'h01, 8'h08, 8'h08, 8'h08, 8'h30, 8'h30, 8'h00, 8'h00};
    logic [3:0] e_md   [8] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h0, 4'h0};
    logic [3:0] e_we;
    load_prog3();
    loop_cnt = 16'd0;
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      e_we = (c <= 6) ? 4'hF : 4'h0;
      total++; if (bg_en !== e_en[c-1]) begin bad++; $display("FAIL single_en c%0d: got %h want %h", c, bg_en, e_en[c-1]); end
      total++; if (bg_flush !== e_fl[c-1]) begin bad++; $display("FAIL single_flush c%0d: got %h want %h", c, bg_flush, e_fl[c-1]); end
      total++; if (bg_fifo_sel !== e_fs[c-1]) begin bad++; $display("FAIL single_fsel c%0d: got %h want %h", c, bg_fifo_sel, e_fs[c-1]); end
      total++; if (bg_mode !== e_md[c-1]) begin bad++; $display("FAIL single_mode c%0d: got %h want %h", c, bg_mode, e_md[c-1]); end
      total++; if (bg_we !== e_we) begin bad++; $display("FAIL single_we c%0d: got %h want %h", c, bg_we, e_we); end
      total++; if (done !== (c == 7)) begin bad++; $display("FAIL single_done c%0d: got %b want %b", c, done, c == 7); end
      total++; if (busy !== (c <= 7)) begin bad++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, c <= 7); end
      if (c < 8) tick();
    end
    $display("single_pass: 3-entry program, 8 cycles checked");
  endtask

  task automatic test_loop();
    int p;
    int ndone = 0;
    logic [3:0] xen, xfl;
    loop_cnt = 16'd2;
    pulse_start();
    for (int c = 1; c <= 20; c++) begin
      p = (c - 1) % 6;
      if (c <= 18) begin
        xen = (p == 0) ? 4'h1 : (p <= 3) ? 4'h3 : 4'hC;
        xfl = (p == 0) ? 4'h1 : (p == 1) ? 4'h2 : 4'h0;
      end else begin
        xen = 4'h0;
        xfl = 4'h0;
      end
      if (done === 1'b1) ndone++;
      total++; if (bg_en !== xen) begin bad++; $display("FAIL loop_en c%0d: got %h want %h", c, bg_en, xen); end
      total++; if (bg_flush !== xfl) begin bad++; $display("FAIL loop_flush c%0d: got %h want %h", c, bg_flush, xfl); end
      total++; if (done !== (c == 19)) begin bad++; $display("FAIL loop_done c%0d: got %b want %b", c, done, c == 19); end
      total++; if (busy !== (c <= 19)) begin bad++; $display("FAIL loop_busy c%0d: got %b want %b", c, busy, c <= 19); end
      if (c < 20) tick();
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL loop_done_count: got %0d want 1", ndone); end
    loop_cnt = 16'd0;
    $display("loop: 3 passes, done pulses=%0d", ndone);
  endtask

  task automatic test_stall();
    logic [3:0] e_en [12] = '{4'h1, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'hC, 4'hC, 4'h0, 4'h0};
    logic [3:0] e_we [12] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
    logic [3:0] e_md [12] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h0, 4'h0};
    logic [3:0] e_fl [12] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      total++; if (bg_en !== e_en[c-1]) begin bad++; $display("FAIL stall_en c%0d: got %h want %h", c, bg_en, e_en[c-1]); end
      total++; if (bg_we !== e_we[c-1]) begin bad++; $display("FAIL stall_we c%0d: got %h want %h", c, bg_we, e_we[c-1]); end
      total++; if (bg_re !== e_we[c-1]) begin bad++; $display("FAIL stall_re c%0d: got %h want %h", c, bg_re, e_we[c-1]); end
      total++; if (bg_mode !== e_md[c-1]) begin bad++; $display("FAIL stall_mode c%0d: got %h want %h", c, bg_mode, e_md[c-1]); end
      total++; if (bg_flush !== e_fl[c-1]) begin bad++; $display("FAIL stall_flush c%0d: got %h want %h", c, bg_flush, e_fl[c-1]); end
      total++; if (done !== (c == 11)) begin bad++; $display("FAIL stall_done c%0d: got %b want %b", c, done, c == 11); end
      total++; if (busy !== (c <= 11)) begin bad++; $display("FAIL stall_busy c%0d: got %b want %b", c, busy, c <= 11); end
      stall = (c >= 2) && (c <= 5);
      if (c < 12) tick();
    end
    stall = 1'b0;
    $display("stall: 4-cycle pause inside E1, 12 cycles checked");
  endtask

  task automatic test_full();
    logic [3:0] iv;
    clear_buf();
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL full_ready_load%0d: got %b want 1", i, cfg_ready); end
      load_entry(mk_ent(8'd0, mk_bg(1'b0, 2'd0, iv[3], 1'b0, 1'b0), mk_bg(1'b0, 2'd0, iv[2], 1'b0, 1'b0),
                        mk_bg(1'b0, 2'd0, iv[1], 1'b0, 1'b0), mk_bg(1'b0, 2'd0, iv[0], 1'b0, 1'b0)));
    end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL full_ready_16: got %b want 0", cfg_ready); end
    // Offer a 17th entry for two cycles; it must be dropped.
    cfg_entry = mk_ent(8'd0, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    cfg_valid = 1'b1;
    tick();
    tick();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL full_ready_17: got %b want 0", cfg_ready); end
    pulse_start();
    for (int c = 1; c <= 18; c++) begin
      iv = (c <= 16) ? 4'(c - 1) : 4'h0;
      total++; if (bg_en !== iv) begin bad++; $display("FAIL full_en c%0d: got %h want %h", c, bg_en, iv); end
      total++; if (done !== (c == 17)) begin bad++; $display("FAIL full_done c%0d: got %b want %b", c, done, c == 17); end
      if (c < 18) tick();
    end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL full_ready_after_run: got %b want 0", cfg_ready); end
    cfg_clear = 1'b1;
    cfg_valid = 1'b1;
    tick();
    cfg_clear = 1'b0;
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL full_ready_cleared: got %b want 1", cfg_ready); end
    // With room available, clear must still beat a same-cycle handshake.
    load_entry(mk_ent(8'd0, 6'd0, 6'd0, 6'd0, mk_bg(1'b0, 2'd0, 1'b1, 1'b0, 1'b0)));
    cfg_clear = 1'b1;
    cfg_valid = 1'b1;
    tick();
    cfg_clear = 1'b0;
    cfg_valid = 1'b0;
    pulse_start();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_clear_priority_busy: got %b want 0", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_clear_priority_busy2: got %b want 0", busy); end
    $display("full: 16 entries, 17th dropped, clear priority checked");
  endtask

  task automatic test_route();
    clear_buf();
    pulse_start();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL route_empty_start: got %b want 0", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL route_empty_start2: got %b want 0", busy); end
    load_entry(mk_ent(8'd3, 6'd0, mk_bg(1'b0, 2'd0, 1'b1, 1'b0, 1'b0),
                      mk_bg(1'b0, 2'd0, 1'b1, 1'b0, 1'b0), mk_bg(1'b0, 2'd0, 1'b1, 1'b1, 1'b0)));
    ex_addr = 8'h5A;
    ex_data = 32'hDEADBEEF;
    sw_addr = 32'h44332211;
    sw_data = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'h12345678};
    ex_wen  = 1'b1;
    ex_ren  = 1'b0;
    sw_wen  = 4'b0000;
    sw_ren  = 4'b0001;
    pulse_start();
    total++; if (bg_addr !== 32'h005A5A11) begin bad++; $display("FAIL route_addr: got %h want 005a5a11", bg_addr); end
    total++; if (bg_din !== {32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678}) begin
      bad++; $display("FAIL route_din: got %h", bg_din); end
    total++; if (bg_we !== 4'b1110) begin bad++; $display("FAIL route_we: got %b want 1110", bg_we); end
    total++; if (bg_re !== 4'b0001) begin bad++; $display("FAIL route_re: got %b want 0001", bg_re); end
    total++; if (bg_en !== 4'b0111) begin bad++; $display("FAIL route_en: got %b want 0111", bg_en); end
    wait_idle("route");
    ex_ren = 1'b1;
    sw_ren = 4'b0000;
    $display("route: sel mux and empty-buffer start checked");
  endtask

  task automatic test_reset_midrun();
    int ndone = 0;
    load_prog3();
    pulse_start();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++; if (bg_en !== 4'h0) begin bad++; $display("FAIL midrst_en: got %h want 0", bg_en); end
    total++; if (bg_we !== 4'h0) begin bad++; $display("FAIL midrst_we: got %h want 0", bg_we); end
    total++; if (bg_addr !== 32'h0) begin bad++; $display("FAIL midrst_addr: got %h want 0", bg_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", cfg_ready); end
    for (int c = 0; c < 9; c++) begin
      if (done !== 1'b0) ndone++;
      tick();
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL midrst_done_count: got %0d want 0", ndone); end
    pulse_start();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_count_zero: busy=%b want 0", busy); end
    $display("reset_midrun: abort without done, buffer count cleared");
  endtask

  initial begin
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_entry = '0;
    cfg_clear = 1'b0;
    start     = 1'b0;
    loop_cnt  = '0;
    stall     = 1'b0;
    ex_wen    = 1'b1;
    ex_ren    = 1'b1;
    ex_addr   = 8'hA5;
    ex_data   = 32'hCAFEF00D;
    sw_wen    = '0;
    sw_ren    = '0;
    sw_addr   = '0;
    sw_data   = '0;
    test_reset();
    test_single_pass();
    test_loop();
    test_stall();
    test_full();
    test_route();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
